commit_queue: RTL and testbench



---
 rtl/commit_queue_pkg.sv | 46 ++++
 rtl/commit_queue_if.sv | 34 +++
 rtl/commit_queue_ptr.sv | 35 +++
 rtl/commit_queue.sv | 142 ++++++++++++++
 tb/tb_commit_queue.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/commit_queue_pkg.sv
// Shared types for the in-order commit queue: entry layout, retire info and FSM states.
package commit_queue_pkg;

    localparam int COMMIT_DEPTH = 64;

    typedef enum logic {
        KIND_WB     = 1'b0,
        KIND_BRANCH = 1'b1
    } commit_kind_t;

    // Both union members are 18 bits with fin in the MSB, so fin can be set without knowing the kind.
    typedef struct packed {
        logic       fin;
        logic [1:0] notify;
        logic [7:0] dest_logic;
        logic [6:0] rsvd;
    } wb_entry_t;

    typedef struct packed {
        logic        fin;
        logic        raise;
        logic [15:0] current_pc;
    } branch_entry_t;

    typedef union packed {
        wb_entry_t     wb;
        branch_entry_t branch;
    } commit_payload_t;

    typedef struct packed {
        commit_kind_t    kind;
        commit_payload_t payload;
    } CommitEntry;

    typedef struct packed {
        logic       en;
        logic [7:0] id;
        logic [7:0] dest_logic;
    } CommitInfo;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } cq_state_t;

endpackage

// File: rtl/commit_queue_if.sv
// Decode push, execution completion and retire/flush signals of the commit queue.
interface commit_queue_if;
    import commit_queue_pkg::*;

    logic        push_en;
    CommitEntry  push_entry;
    logic [7:0]  push_commit_id;
    logic        full;

    logic        complete_en;
    logic [7:0]  complete_id;
    logic        complete_raise;
    logic [15:0] complete_pc;

    logic        commit_en;
    logic [7:0]  commit_id;
    logic [7:0]  commit_dest_logic;
    logic [1:0]  notify;
    logic        flash;
    logic [15:0] flash_pc;

    modport master (
        output push_en, push_entry, complete_en, complete_id, complete_raise, complete_pc,
        input  push_commit_id, full, commit_en, commit_id, commit_dest_logic, notify,
               flash, flash_pc
    );

    modport slave (
        input  push_en, push_entry, complete_en, complete_id, complete_raise, complete_pc,
        output push_commit_id, full, commit_en, commit_id, commit_dest_logic, notify,
               flash, flash_pc
    );

endinterface

// File: rtl/commit_queue_ptr.sv
// Head/tail pointer pair with one extra wrap bit, full/empty derivation and synchronous clear.
module commit_queue_ptr #(
    parameter int AW = 6
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        inc_head,
    input  logic        inc_tail,
    input  logic        clear,
    output logic [AW:0] head,
    output logic [AW:0] tail,
    output logic        full,
    output logic        empty
);

    localparam logic [AW:0] ONE = (AW + 1)'(1);

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head <= '0;
            tail <= '0;
        end else if (clear) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (inc_head) head <= head + ONE;
            if (inc_tail) tail <= tail + ONE;
        end
    end

    assign empty = (head == tail);
    assign full  = (head[AW] != tail[AW]) && (head[AW-1:0] == tail[AW-1:0]);

endmodule

// File: rtl/commit_queue.sv
// In-order commit queue (reorder buffer): allocates ids at decode, records completions,
// retires in program order and flushes on a mispredicted branch.
// Optional perf counters are built when COMMIT_QUEUE_PERF_EN is defined.
module commit_queue
    import commit_queue_pkg::*;
#(
    parameter  int DEPTH = COMMIT_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clock,
    input  logic        reset_n,
    commit_queue_if.slave bus
`ifdef COMMIT_QUEUE_PERF_EN
    ,
    output logic [31:0] perf_commits,
    output logic [31:0] perf_flashes
`endif
);

    logic [AW:0]      head;
    logic [AW:0]      tail;
    logic             full;
    logic             empty;
    logic [DEPTH-1:0] valid;
    CommitEntry       mem [DEPTH];
    CommitEntry       head_entry;
    CommitInfo        info;
    cq_state_t        state_q;
    cq_state_t        state_d;
    logic [15:0]      flash_pc_q;

    logic [AW-1:0] head_idx;
    logic [AW-1:0] tail_idx;
    logic [AW-1:0] cidx;
    logic          head_valid;
    logic          push_ok;
    logic          complete_ok;
    logic          retire;
    logic          flush_req;
    logic          in_flush;
    logic          unused_id_bits;

    assign head_idx       = head[AW-1:0];
    assign tail_idx       = tail[AW-1:0];
    assign cidx           = bus.complete_id[AW-1:0];
    assign unused_id_bits = ^bus.complete_id;

    assign in_flush    = (state_q == FLUSH);
    assign head_entry  = mem[head_idx];
    assign head_valid  = !empty && valid[head_idx];
    assign push_ok     = bus.push_en && !full && !in_flush;
    assign complete_ok = bus.complete_en && valid[cidx] && !in_flush;
    assign retire      = head_valid && head_entry.payload.wb.fin;
    assign flush_req   = retire && (head_entry.kind == KIND_BRANCH) &&
                         head_entry.payload.branch.raise;

    commit_queue_ptr #(.AW(AW)) u_ptr (
        .clock    (clock),
        .reset_n  (reset_n),
        .inc_head (retire),
        .inc_tail (push_ok),
        .clear    (flush_req),
        .head     (head),
        .tail     (tail),
        .full     (full),
        .empty    (empty)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid <= '0;
        end else if (flush_req) begin
            valid <= '0;
        end else begin
            if (push_ok) valid[tail_idx] <= 1'b1;
            if (retire)  valid[head_idx] <= 1'b0;
        end
    end

    // NOTE: entry storage has no reset; only the valid bits qualify its contents.
    always_ff @(posedge clock) begin
        if (push_ok) mem[tail_idx] <= bus.push_entry;
        if (complete_ok) begin
            mem[cidx].payload.wb.fin <= 1'b1;
            if (mem[cidx].kind == KIND_BRANCH) begin
                mem[cidx].payload.branch.raise <= bus.complete_raise;
                if (bus.complete_raise) mem[cidx].payload.branch.current_pc <= bus.complete_pc;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RUN;
            flash_pc_q <= '0;
        end else begin
            state_q <= state_d;
            if (flush_req) flash_pc_q <= head_entry.payload.branch.current_pc;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:   if (flush_req) state_d = FLUSH;
            FLUSH: state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        info            = '0;
        info.en         = retire;
        info.id         = 8'(head_idx);
        if (retire && head_entry.kind == KIND_WB) info.dest_logic = head_entry.payload.wb.dest_logic;
        bus.notify = 2'b00;
        if (head_valid && head_entry.kind == KIND_WB && !head_entry.payload.wb.fin)
            bus.notify = head_entry.payload.wb.notify;
    end

    assign bus.push_commit_id    = 8'(tail_idx);
    assign bus.full              = full;
    assign bus.commit_en         = info.en;
    assign bus.commit_id         = info.id;
    assign bus.commit_dest_logic = info.dest_logic;
    assign bus.flash             = in_flush;
    assign bus.flash_pc          = flash_pc_q;

`ifdef COMMIT_QUEUE_PERF_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_commits <= '0;
            perf_flashes <= '0;
        end else begin
            if (info.en && perf_commits != '1) perf_commits <= perf_commits + 32'd1;
            if (in_flush && perf_flashes != '1) perf_flashes <= perf_flashes + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_commit_queue.sv
// Directed self-checking bench for commit_queue (DEPTH=4); perf counters checked when
// COMMIT_QUEUE_PERF_EN is defined.
module tb_commit_queue;
    import commit_queue_pkg::*;

    logic clock;
    logic reset_n;
    int   n_pass  = 0;
    int   n_total = 0;

    commit_queue_if cq_if ();

`ifdef COMMIT_QUEUE_PERF_EN
    logic [31:0] perf_commits;
    logic [31:0] perf_flashes;
`endif

    commit_queue #(.DEPTH(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (cq_if)
`ifdef COMMIT_QUEUE_PERF_EN
        ,
        .perf_commits (perf_commits),
        .perf_flashes (perf_flashes)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic CommitEntry wb_entry(input logic [7:0] dest, input logic [1:0] ntf,
                                            input logic fin);
        CommitEntry e;
        e = '0;
        e.kind                  = KIND_WB;
        e.payload.wb.fin        = fin;
        e.payload.wb.notify     = ntf;
        e.payload.wb.dest_logic = dest;
        return e;
    endfunction

    function automatic CommitEntry br_entry(input logic [15:0] pc);
        CommitEntry e;
        e = '0;
        e.kind                      = KIND_BRANCH;
        e.payload.branch.current_pc = pc;
        return e;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        cq_if.push_en        = 1'b0;
        cq_if.push_entry     = '0;
        cq_if.complete_en    = 1'b0;
        cq_if.complete_id    = '0;
        cq_if.complete_raise = 1'b0;
        cq_if.complete_pc    = '0;
    endtask

    task automatic push(input CommitEntry e);
        cq_if.push_en    = 1'b1;
        cq_if.push_entry = e;
    endtask

    task automatic complete(input logic [7:0] id, input logic raise, input logic [15:0] pc);
        cq_if.complete_en    = 1'b1;
        cq_if.complete_id    = id;
        cq_if.complete_raise = raise;
        cq_if.complete_pc    = pc;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        tick();
    endtask

    logic [7:0] exp_dest [4];

    initial begin
        idle();
        reset_n = 1'b0;
        #1;
        check("rst_full",     32'(cq_if.full), 0);
        check("rst_commit",   32'(cq_if.commit_en), 0);
        check("rst_notify",   32'(cq_if.notify), 0);
        check("rst_flash",    32'(cq_if.flash), 0);
        check("rst_flash_pc", 32'(cq_if.flash_pc), 0);
        check("rst_push_id",  32'(cq_if.push_commit_id), 0);
        #2;
        reset_n = 1'b1;
        tick();

        // In-order retire with out-of-order completion.
        for (int i = 0; i < 3; i++) begin
            push(wb_entry(8'(5 + i), 2'b00, 1'b0));
            #1;
            check("alloc_id", 32'(cq_if.push_commit_id), 32'(i));
            tick();
        end
        idle();
        #1;
        check("unfinished_no_retire", 32'(cq_if.commit_en), 0);
        complete(8'd1, 1'b0, 16'h0);
        #1;
        check("younger_done_no_retire", 32'(cq_if.commit_en), 0);
        tick();
        complete(8'd0, 1'b0, 16'h0);
        #1;
        check("same_cycle_complete_no_retire", 32'(cq_if.commit_en), 0);
        tick();
        idle();
        #1;
        check("retire0_en",   32'(cq_if.commit_en), 1);
        check("retire0_id",   32'(cq_if.commit_id), 0);
        check("retire0_dest", 32'(cq_if.commit_dest_logic), 5);
        tick();
        check("retire1_en",   32'(cq_if.commit_en), 1);
        check("retire1_id",   32'(cq_if.commit_id), 1);
        check("retire1_dest", 32'(cq_if.commit_dest_logic), 6);
        tick();
        check("id2_pending", 32'(cq_if.commit_en), 0);

        // Fill to full, drop on full, wrap-around id reuse.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            push(wb_entry(8'(8'h10 + k), 2'b00, 1'b0));
            #1;
            check("fill_id",   32'(cq_if.push_commit_id), 32'(k));
            check("fill_full", 32'(cq_if.full), 0);
            tick();
        end
        push(wb_entry(8'h14, 2'b00, 1'b0));
        #1;
        check("full_after_4", 32'(cq_if.full), 1);
        tick();
        idle();
        #1;
        check("full_after_drop", 32'(cq_if.full), 1);
        complete(8'd0, 1'b0, 16'h0);
        tick();
        idle();
        push(wb_entry(8'h33, 2'b00, 1'b0));
        #1;
        check("full_retire_en",   32'(cq_if.commit_en), 1);
        check("full_retire_dest", 32'(cq_if.commit_dest_logic), 32'h10);
        check("full_during_retire", 32'(cq_if.full), 1);
        tick();
        idle();
        #1;
        check("not_full_after_retire", 32'(cq_if.full), 0);
        check("wrap_reuse_id", 32'(cq_if.push_commit_id), 0);
        push(wb_entry(8'h44, 2'b00, 1'b0));
        tick();
        idle();
        #1;
        check("full_again", 32'(cq_if.full), 1);
        complete(8'd0, 1'b0, 16'h0); tick();
        complete(8'd3, 1'b0, 16'h0); tick();
        complete(8'd2, 1'b0, 16'h0); tick();
        complete(8'd1, 1'b0, 16'h0); tick();
        idle();
        #1;
        exp_dest[0] = 8'h11;
        exp_dest[1] = 8'h12;
        exp_dest[2] = 8'h13;
        exp_dest[3] = 8'h44;
        for (int j = 0; j < 4; j++) begin
            check("drain_en",   32'(cq_if.commit_en), 1);
            check("drain_dest", 32'(cq_if.commit_dest_logic), 32'(exp_dest[j]));
            tick();
        end
        check("drained_idle", 32'(cq_if.commit_en), 0);
        check("drained_full", 32'(cq_if.full), 0);

        // Mispredicted branch flush.
        do_reset();
        push(br_entry(16'h0010));
        #1;
        check("br_id", 32'(cq_if.push_commit_id), 0);
        tick();
        push(wb_entry(8'd9, 2'b00, 1'b0));
        tick();
        idle();
        complete(8'd1, 1'b0, 16'h0);
        tick();
        complete(8'd0, 1'b1, 16'h0040);
        #1;
        check("br_not_yet", 32'(cq_if.commit_en), 0);
        tick();
        idle();
        #1;
        check("br_retire_en",   32'(cq_if.commit_en), 1);
        check("br_retire_id",   32'(cq_if.commit_id), 0);
        check("br_retire_dest", 32'(cq_if.commit_dest_logic), 0);
        check("flash_not_yet",  32'(cq_if.flash), 0);
        tick();
        check("flash_on",       32'(cq_if.flash), 1);
        check("flash_pc",       32'(cq_if.flash_pc), 32'h0040);
        check("flash_no_commit", 32'(cq_if.commit_en), 0);
        check("flash_tail_zero", 32'(cq_if.push_commit_id), 0);
        push(wb_entry(8'h55, 2'b00, 1'b1));
        tick();
        idle();
        #1;
        check("flash_one_cycle",   32'(cq_if.flash), 0);
        check("flushed_wb_no_commit", 32'(cq_if.commit_en), 0);
        check("push_in_flash_dropped", 32'(cq_if.push_commit_id), 0);
        push(wb_entry(8'h21, 2'b00, 1'b1));
        tick();
        idle();
        #1;
        check("fin_at_push_en",   32'(cq_if.commit_en), 1);
        check("fin_at_push_dest", 32'(cq_if.commit_dest_logic), 32'h21);
        tick();
        push(br_entry(16'h0080));
        tick();
        idle();
        complete(8'd1, 1'b0, 16'h0999);
        tick();
        idle();
        #1;
        check("br_ok_en",   32'(cq_if.commit_en), 1);
        check("br_ok_dest", 32'(cq_if.commit_dest_logic), 0);
        tick();
        check("br_ok_no_flash", 32'(cq_if.flash), 0);

        // Notify while the head waits for its side effect.
        push(wb_entry(8'd3, 2'b01, 1'b0));
        tick();
        idle();
        #1;
        check("notify_on", 32'(cq_if.notify), 32'b01);
        tick();
        check("notify_hold", 32'(cq_if.notify), 32'b01);
        complete(8'd2, 1'b0, 16'h0);
        #1;
        check("notify_during_complete", 32'(cq_if.notify), 32'b01);
        tick();
        idle();
        #1;
        check("notify_off",   32'(cq_if.notify), 0);
        check("notify_retire", 32'(cq_if.commit_dest_logic), 3);
        tick();

        // Completion to an invalid slot is ignored.
        complete(8'd7, 1'b1, 16'h1234);
        tick();
        idle();
        #1;
        check("inv_commit",  32'(cq_if.commit_en), 0);
        check("inv_full",    32'(cq_if.full), 0);
        check("inv_push_id", 32'(cq_if.push_commit_id), 3);
        check("inv_flash",   32'(cq_if.flash), 0);
        tick();
        check("inv_no_flash_later", 32'(cq_if.flash), 0);

        // Asynchronous reset with entries pending.
        push(wb_entry(8'd1, 2'b10, 1'b0)); tick();
        push(wb_entry(8'd2, 2'b00, 1'b0)); tick();
        push(wb_entry(8'd3, 2'b00, 1'b0)); tick();
        idle();
        #1;
        check("pre_rst_notify", 32'(cq_if.notify), 32'b10);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_push_id",  32'(cq_if.push_commit_id), 0);
        check("arst_full",     32'(cq_if.full), 0);
        check("arst_commit",   32'(cq_if.commit_en), 0);
        check("arst_notify",   32'(cq_if.notify), 0);
        check("arst_flash",    32'(cq_if.flash), 0);
        check("arst_flash_pc", 32'(cq_if.flash_pc), 0);
        #1;
        reset_n = 1'b1;
        tick();
        check("post_rst_commit", 32'(cq_if.commit_en), 0);

`ifdef COMMIT_QUEUE_PERF_EN
        do_reset();
        for (int i = 0; i < 9; i++) begin
            push(wb_entry(8'(i), 2'b00, 1'b1));
            tick();
        end
        push(br_entry(16'h0100));
        tick();
        idle();
        complete(8'd1, 1'b1, 16'h0200);
        tick();
        idle();
        tick();
        tick();
        tick();
        check("perf_commits", perf_commits, 32'd10);
        check("perf_flashes", perf_flashes, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
